// File: rtl/mips_bus_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM states, grant owner
// and the full-word byte-enable used for instruction fetches.
package mips_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DATA,
        RESP,
        HALT
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH,
        GNT_DATA
    } grant_t;

    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

endpackage

// File: rtl/mips_wait_watchdog.sv
// Counts consecutive waitrequest stall cycles of one bus access.
// expired is registered and high while the next stall would be the LIMIT-th.
module mips_wait_watchdog #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic        r_expired;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clear) begin
            w_cnt_nxt = '0;
        end else if (stall) begin
            w_cnt_nxt = r_cnt + 32'd1;
        end
    end

    // Look one stall ahead so the FSM can abort on the edge the count reaches LIMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_expired <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_expired <= (w_cnt_nxt == 32'(LIMIT - 1));
        end
    end

    assign expired = r_expired;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the single Avalon-style memory port between instruction fetch
// and load/store, holding the bus stable across waitrequest.
module mips_mem_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ROUND_ROBIN = 1,
    parameter int WAIT_LIMIT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_addr,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic             fetch_misaligned,
    input  logic             data_req,
    input  logic             data_write,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    input  logic [3:0]       data_byteenable,
    output logic             data_done,
    output logic [31:0]      data_rdata,
    output logic [31:0]      address,
    output logic             read,
    output logic             write,
    output logic [31:0]      writedata,
    output logic [3:0]       byteenable,
    input  logic             waitrequest,
    input  logic [31:0]      readdata,
    output logic             bus_error,
    output arb_state_t       dbg_state
);

    arb_state_t  r_state, w_state_nxt;
    grant_t      r_last_grant, w_last_grant;
    logic        r_misal, w_misal;
    logic [31:0] r_address, w_address;
    logic        r_read, w_read;
    logic        r_write, w_write;
    logic [31:0] r_writedata, w_writedata;
    logic [3:0]  r_byteenable, w_byteenable;
    logic [31:0] r_instr, w_instr;
    logic [31:0] r_data_rdata, w_data_rdata;
    logic        r_instr_valid, w_instr_valid;
    logic        r_data_done, w_data_done;
    logic        r_fetch_misaligned, w_fetch_misaligned;
    logic        r_bus_error, w_bus_error;

    logic        w_grant_fetch;
    logic        w_grant_data;
    logic        w_stall;
    logic        w_expired;

    always_comb begin
        w_grant_fetch = 1'b0;
        w_grant_data  = 1'b0;
        if (r_state == IDLE) begin
            w_grant_fetch = fetch_req &&
                            (!data_req || (ROUND_ROBIN != 0 && r_last_grant == GNT_DATA));
            w_grant_data  = data_req && !w_grant_fetch;
        end
    end

    assign w_stall = waitrequest &&
                     ((r_state == FETCH && !r_misal) || r_state == DATA);

    generate
        if (WAIT_LIMIT > 0) begin : g_watchdog
            mips_wait_watchdog #(.LIMIT(WAIT_LIMIT)) u_watchdog (
                .clk     (clk),
                .reset   (reset),
                .clear   (w_grant_fetch || w_grant_data),
                .stall   (w_stall),
                .expired (w_expired)
            );
        end else begin : g_no_watchdog
            assign w_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A misaligned fetch spends one strobe-less cycle in FETCH so its pulse
    // lands at the same latency as a real fetch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_fetch) begin
                    w_state_nxt = FETCH;
                end else if (w_grant_data) begin
                    w_state_nxt = DATA;
                end
            end
            FETCH: begin
                if (r_misal || !waitrequest) begin
                    w_state_nxt = RESP;
                end else if (w_expired) begin
                    w_state_nxt = HALT;
                end
            end
            DATA: begin
                if (!waitrequest) begin
                    w_state_nxt = RESP;
                end else if (w_expired) begin
                    w_state_nxt = HALT;
                end
            end
            RESP:    w_state_nxt = IDLE;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_last_grant       = r_last_grant;
        w_misal            = r_misal;
        w_address          = r_address;
        w_read             = r_read;
        w_write            = r_write;
        w_writedata        = r_writedata;
        w_byteenable       = r_byteenable;
        w_instr            = r_instr;
        w_data_rdata       = r_data_rdata;
        w_instr_valid      = 1'b0;
        w_data_done        = 1'b0;
        w_fetch_misaligned = 1'b0;
        w_bus_error        = r_bus_error;
        case (r_state)
            IDLE: begin
                if (w_grant_fetch) begin
                    w_address    = fetch_addr;
                    w_byteenable = BYTEEN_WORD;
                    w_misal      = (fetch_addr[1:0] != 2'b00);
                    w_read       = (fetch_addr[1:0] == 2'b00);
                    w_write      = 1'b0;
                end else if (w_grant_data) begin
                    w_address    = data_addr;
                    w_writedata  = data_wdata;
                    w_byteenable = data_byteenable;
                    w_misal      = 1'b0;
                    w_read       = !data_write;
                    w_write      = data_write;
                end
            end
            FETCH: begin
                if (r_misal) begin
                    w_instr_valid      = 1'b1;
                    w_fetch_misaligned = 1'b1;
                end else if (!waitrequest) begin
                    w_instr       = readdata;
                    w_instr_valid = 1'b1;
                    w_read        = 1'b0;
                end else if (w_expired) begin
                    w_read      = 1'b0;
                    w_bus_error = 1'b1;
                end
            end
            DATA: begin
                if (!waitrequest) begin
                    if (r_read) begin
                        w_data_rdata = readdata;
                    end
                    w_data_done = 1'b1;
                    w_read      = 1'b0;
                    w_write     = 1'b0;
                end else if (w_expired) begin
                    w_read      = 1'b0;
                    w_write     = 1'b0;
                    w_bus_error = 1'b1;
                end
            end
            RESP: begin
                w_last_grant = r_misal ? GNT_FETCH :
                               (r_address == r_address && r_data_done) ? GNT_DATA : GNT_FETCH;
            end
            HALT: begin
                w_read  = 1'b0;
                w_write = 1'b0;
            end
            default: begin
                w_read  = 1'b0;
                w_write = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant       <= GNT_DATA;
            r_misal            <= 1'b0;
            r_address          <= '0;
            r_read             <= 1'b0;
            r_write            <= 1'b0;
            r_writedata        <= '0;
            r_byteenable       <= '0;
            r_instr            <= '0;
            r_data_rdata       <= '0;
            r_instr_valid      <= 1'b0;
            r_data_done        <= 1'b0;
            r_fetch_misaligned <= 1'b0;
            r_bus_error        <= 1'b0;
        end else begin
            r_last_grant       <= w_last_grant;
            r_misal            <= w_misal;
            r_address          <= w_address;
            r_read             <= w_read;
            r_write            <= w_write;
            r_writedata        <= w_writedata;
            r_byteenable       <= w_byteenable;
            r_instr            <= w_instr;
            r_data_rdata       <= w_data_rdata;
            r_instr_valid      <= w_instr_valid;
            r_data_done        <= w_data_done;
            r_fetch_misaligned <= w_fetch_misaligned;
            r_bus_error        <= w_bus_error;
        end
    end

    assign address          = r_address;
    assign read             = r_read;
    assign write            = r_write;
    assign writedata        = r_writedata;
    assign byteenable       = r_byteenable;
    assign instr            = r_instr;
    assign instr_valid      = r_instr_valid;
    assign fetch_misaligned = r_fetch_misaligned;
    assign data_rdata       = r_data_rdata;
    assign data_done        = r_data_done;
    assign bus_error        = r_bus_error;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: round-robin, data-priority and
// watchdog-enabled instances driven from one shared stimulus.
module tb_mips_mem_arbiter;
    import mips_bus_pkg::*;

    typedef struct {
        logic        freq;
        logic [31:0] faddr;
        logic        dreq;
        logic        dwr;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dbe;
        logic        wreq;
        logic [31:0] rdata;
        logic        e_read;
        logic        e_write;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        e_ivalid;
        logic [31:0] e_instr;
        logic        e_misal;
        logic        e_done;
        logic [31:0] e_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        data_req;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    logic a_instr_valid, a_fetch_misaligned, a_data_done, a_read, a_write, a_bus_error;
    logic [31:0] a_instr, a_data_rdata, a_address, a_writedata;
    logic [3:0]  a_byteenable;
    arb_state_t  a_dbg_state;
    logic b_instr_valid, b_fetch_misaligned, b_data_done, b_read, b_write, b_bus_error;
    logic [31:0] b_instr, b_data_rdata, b_address, b_writedata;
    logic [3:0]  b_byteenable;
    arb_state_t  b_dbg_state;
    logic c_instr_valid, c_fetch_misaligned, c_data_done, c_read, c_write, c_bus_error;
    logic [31:0] c_instr, c_data_rdata, c_address, c_writedata;
    logic [3:0]  c_byteenable;
    arb_state_t  c_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mips_mem_arbiter #(.ROUND_ROBIN(1), .WAIT_LIMIT(0)) u_rr (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .instr_valid(a_instr_valid), .instr(a_instr), .fetch_misaligned(a_fetch_misaligned),
        .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_byteenable(data_byteenable),
        .data_done(a_data_done), .data_rdata(a_data_rdata), .address(a_address),
        .read(a_read), .write(a_write), .writedata(a_writedata), .byteenable(a_byteenable),
        .waitrequest(waitrequest), .readdata(readdata), .bus_error(a_bus_error),
        .dbg_state(a_dbg_state)
    );

    mips_mem_arbiter #(.ROUND_ROBIN(0), .WAIT_LIMIT(0)) u_prio (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .instr_valid(b_instr_valid), .instr(b_instr), .fetch_misaligned(b_fetch_misaligned),
        .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_byteenable(data_byteenable),
        .data_done(b_data_done), .data_rdata(b_data_rdata), .address(b_address),
        .read(b_read), .write(b_write), .writedata(b_writedata), .byteenable(b_byteenable),
        .waitrequest(waitrequest), .readdata(readdata), .bus_error(b_bus_error),
        .dbg_state(b_dbg_state)
    );

    mips_mem_arbiter #(.ROUND_ROBIN(1), .WAIT_LIMIT(4)) u_wd (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .instr_valid(c_instr_valid), .instr(c_instr), .fetch_misaligned(c_fetch_misaligned),
        .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_byteenable(data_byteenable),
        .data_done(c_data_done), .data_rdata(c_data_rdata), .address(c_address),
        .read(c_read), .write(c_write), .writedata(c_writedata), .byteenable(c_byteenable),
        .waitrequest(waitrequest), .readdata(readdata), .bus_error(c_bus_error),
        .dbg_state(c_dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic vec_t mkv(
        input logic fq, input logic [31:0] fa, input logic dq, input logic dw,
        input logic [31:0] da, input logic [31:0] dd, input logic [3:0] db,
        input logic wr, input logic [31:0] rd,
        input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
        input logic [3:0] eb, input logic ev, input logic [31:0] ei, input logic em,
        input logic edn, input logic [31:0] erd);
        vec_t v;
        v = '{fq, fa, dq, dw, da, dd, db, wr, rd, er, ew, ea, ed, eb, ev, ei, em, edn, erd};
        return v;
    endfunction

    initial begin
        // Fetch only: strobe in cycle 1, pulse in cycle 2.
        vecs.push_back(mkv(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 32'h24020005,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 32'h24020005,  1, 0, 32'hBFC00000, 0, 4'hF, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 32'h24020005,  0, 0, 32'hBFC00000, 0, 4'hF, 1, 32'h24020005, 0, 0, 0));
        vecs.push_back(mkv(0, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'hBFC00000, 0, 4'hF, 0, 32'h24020005, 0, 0, 0));
        // Store stalled three cycles.
        vecs.push_back(mkv(0, 0, 1, 1, 32'h1000, 32'hDEADBEEF, 4'h3, 0, 0,   0, 0, 32'hBFC00000, 0, 4'hF, 0, 32'h24020005, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkv(0, 0, 1, 1, 32'h1000, 32'hDEADBEEF, 4'h3, 1, 0, 0, 1, 32'h1000, 32'hDEADBEEF, 4'h3, 0, 32'h24020005, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 1, 32'h1000, 32'hDEADBEEF, 4'h3, 0, 0,   0, 1, 32'h1000, 32'hDEADBEEF, 4'h3, 0, 32'h24020005, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 32'h1000, 32'hDEADBEEF, 4'h3, 0, 0,   0, 0, 32'h1000, 32'hDEADBEEF, 4'h3, 0, 32'h24020005, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h1000, 32'hDEADBEEF, 4'h3, 0, 32'h24020005, 0, 0, 0));
        // Tie with round robin: fetch, data, fetch.
        vecs.push_back(mkv(1, 32'h100, 1, 0, 32'h2000, 0, 4'hF, 0, 0,          0, 0, 32'h1000, 32'hDEADBEEF, 4'h3, 0, 32'h24020005, 0, 0, 0));
        vecs.push_back(mkv(1, 32'h100, 1, 0, 32'h2000, 0, 4'hF, 0, 32'hA001,   1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h24020005, 0, 0, 0));
        vecs.push_back(mkv(1, 32'h100, 1, 0, 32'h2000, 0, 4'hF, 0, 32'hA001,   0, 0, 32'h100, 32'hDEADBEEF, 4'hF, 1, 32'hA001, 0, 0, 0));
        vecs.push_back(mkv(1, 32'h100, 1, 0, 32'h2000, 0, 4'hF, 0, 0,          0, 0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'hA001, 0, 0, 0));
        vecs.push_back(mkv(1, 32'h100, 1, 0, 32'h2000, 0, 4'hF, 0, 32'hD002,   1, 0, 32'h2000, 0, 4'hF, 0, 32'hA001, 0, 0, 0));
        vecs.push_back(mkv(1, 32'h100, 1, 0, 32'h2000, 0, 4'hF, 0, 32'hD002,   0, 0, 32'h2000, 0, 4'hF, 0, 32'hA001, 0, 1, 32'hD002));
        vecs.push_back(mkv(1, 32'h100, 1, 0, 32'h2000, 0, 4'hF, 0, 0,          0, 0, 32'h2000, 0, 4'hF, 0, 32'hA001, 0, 0, 32'hD002));
        vecs.push_back(mkv(1, 32'h100, 1, 0, 32'h2000, 0, 4'hF, 0, 32'hA003,   1, 0, 32'h100, 0, 4'hF, 0, 32'hA001, 0, 0, 32'hD002));
        vecs.push_back(mkv(0, 32'h100, 0, 0, 32'h2000, 0, 4'hF, 0, 32'hA003,   0, 0, 32'h100, 0, 4'hF, 1, 32'hA003, 0, 0, 32'hD002));
        vecs.push_back(mkv(0, 32'h100, 0, 0, 32'h2000, 0, 4'hF, 0, 0,          0, 0, 32'h100, 0, 4'hF, 0, 32'hA003, 0, 0, 32'hD002));

        reset = 1'b1;
        fetch_req = 0; fetch_addr = 0; data_req = 0; data_write = 0; data_addr = 0;
        data_wdata = 0; data_byteenable = 0; waitrequest = 0; readdata = 0;
        step();
        step();
        chk("reset_state", a_dbg_state, IDLE);
        chk("reset_read", a_read, 0);
        chk("reset_write", a_write, 0);
        chk("reset_address", a_address, 0);
        chk("reset_byteenable", a_byteenable, 0);
        chk("reset_bus_error", a_bus_error, 0);
        chk("reset_pulses", {a_instr_valid, a_data_done, a_fetch_misaligned}, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            fetch_req = vecs[i].freq; fetch_addr = vecs[i].faddr;
            data_req = vecs[i].dreq; data_write = vecs[i].dwr; data_addr = vecs[i].daddr;
            data_wdata = vecs[i].dwdata; data_byteenable = vecs[i].dbe;
            waitrequest = vecs[i].wreq; readdata = vecs[i].rdata;
            chk($sformatf("v%0d_read", i), a_read, vecs[i].e_read);
            chk($sformatf("v%0d_write", i), a_write, vecs[i].e_write);
            chk($sformatf("v%0d_address", i), a_address, vecs[i].e_addr);
            chk($sformatf("v%0d_writedata", i), a_writedata, vecs[i].e_wdata);
            chk($sformatf("v%0d_byteenable", i), a_byteenable, vecs[i].e_be);
            chk($sformatf("v%0d_instr_valid", i), a_instr_valid, vecs[i].e_ivalid);
            chk($sformatf("v%0d_instr", i), a_instr, vecs[i].e_instr);
            chk($sformatf("v%0d_misaligned", i), a_fetch_misaligned, vecs[i].e_misal);
            chk($sformatf("v%0d_data_done", i), a_data_done, vecs[i].e_done);
            chk($sformatf("v%0d_data_rdata", i), a_data_rdata, vecs[i].e_rdata);
            step();
        end

        // Misaligned fetch: never a strobe, pulse two cycles later, instr kept.
        fetch_req = 1; fetch_addr = 32'h00000402;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("misal_c%0d_read", c), a_read, 0);
            chk($sformatf("misal_c%0d_valid", c), a_instr_valid, (c == 2) ? 1 : 0);
            chk($sformatf("misal_c%0d_flag", c), a_fetch_misaligned, (c == 2) ? 1 : 0);
            if (c == 2) begin
                chk("misal_instr_kept", a_instr, 32'hA003);
                fetch_req = 0;
            end
            step();
        end

        // Reset while a load is stalled: strobes drop, no completion.
        data_req = 1; data_write = 0; data_addr = 32'h4000; waitrequest = 1;
        step();
        chk("rst_mid_c1_read", a_read, 1);
        step();
        chk("rst_mid_c2_read", a_read, 1);
        reset = 1;
        step();
        chk("rst_mid_read", a_read, 0);
        chk("rst_mid_write", a_write, 0);
        chk("rst_mid_state", a_dbg_state, IDLE);
        reset = 0; data_req = 0; waitrequest = 0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rst_mid_done_c%0d", c), a_data_done, 0);
            step();
        end

        // Data-priority instance: data wins every tie until data_req drops.
        do_reset();
        fetch_req = 1; fetch_addr = 32'h100;
        data_req = 1; data_write = 0; data_addr = 32'h3000; data_byteenable = 4'hF;
        readdata = 32'h0000B001;
        step();
        chk("prio_c1_address", b_address, 32'h3000);
        chk("prio_c1_read", b_read, 1);
        chk("rr_first_tie_fetch", a_address, 32'h100);
        step();
        chk("prio_c2_done", b_data_done, 1);
        chk("prio_c2_rdata", b_data_rdata, 32'h0000B001);
        step();
        step();
        chk("prio_c4_address", b_address, 32'h3000);
        chk("prio_c4_read", b_read, 1);
        step();
        chk("prio_c5_done", b_data_done, 1);
        data_req = 0;
        step();
        step();
        chk("prio_c7_address", b_address, 32'h100);
        chk("prio_c7_read", b_read, 1);
        step();
        chk("prio_c8_valid", b_instr_valid, 1);
        fetch_req = 0;
        step();

        // Watchdog instance: stuck waitrequest aborts after four stall cycles.
        do_reset();
        fetch_req = 1; fetch_addr = 32'hBFC00000; waitrequest = 1; readdata = 32'h24020005;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("wd_c%0d_read", c), c_read, 1);
            chk($sformatf("wd_c%0d_bus_error", c), c_bus_error, 0);
        end
        step();
        chk("wd_abort_read", c_read, 0);
        chk("wd_abort_bus_error", c_bus_error, 1);
        chk("wd_abort_state", c_dbg_state, HALT);
        waitrequest = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("wd_halt_c%0d_valid", c), c_instr_valid, 0);
            chk($sformatf("wd_halt_c%0d_read", c), c_read, 0);
            chk($sformatf("wd_halt_c%0d_bus_error", c), c_bus_error, 1);
        end
        do_reset();
        chk("wd_reset_bus_error", c_bus_error, 0);
        step();
        chk("wd_after_c1_read", c_read, 1);
        chk("wd_after_c1_address", c_address, 32'hBFC00000);
        step();
        chk("wd_after_c2_valid", c_instr_valid, 1);
        chk("wd_after_c2_instr", c_instr, 32'h24020005);
        fetch_req = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the CPU's single Avalon-style memory port between the instruction-fetch requester and the load/store requester.
- Latches the request, holds address/control stable across waitrequest, and captures readdata.
- Returns a one-cycle completion pulse to the requester that owns the access.
- Sits between the CPU core (fetch/decode and memory stages) and the external memory bus, and replaces ad hoc waitrequest handling in the fetch path.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate grants when both requesters are pending; 0 = data requester always wins.
- WAIT_LIMIT, 0: maximum consecutive waitrequest cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request, level
- fetch_addr  in  32  fetch byte address
- instr_valid  out  1  one-cycle pulse: instr holds the fetched word (or fetch_misaligned is set)
- instr  out  32  fetched instruction, registered
- fetch_misaligned  out  1  valid with instr_valid; fetch_addr[1:0]!=0
- data_req  in  1  load/store request, level
- data_write  in  1  1 = store, 0 = load
- data_addr  in  32  data byte address, word-aligned by CPU
- data_wdata  in  32  store data
- data_byteenable  in  4  byte lanes
- data_done  out  1  one-cycle completion pulse
- data_rdata  out  32  load data, registered
- address  out  32  memory address
- read  out  1  memory read strobe
- write  out  1  memory write strobe
- writedata  out  32  memory write data
- byteenable  out  4  memory byte lanes (4'b1111 for fetch)
- waitrequest  in  1  memory stall
- readdata  in  32  memory read data, valid in the cycle waitrequest=0 while read=1
- bus_error  out  1  sticky: watchdog abort occurred

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; read=write=0; address, writedata, instr, data_rdata = 0; byteenable=0; instr_valid=data_done=fetch_misaligned=bus_error=0; last_grant=DATA, so fetch wins the first tie.
- FSM states: IDLE, FETCH, DATA, RESP, HALT.
- IDLE: sample the requests.
  - Neither pending: stay in IDLE.
  - Only one pending: grant it.
  - Both pending: if ROUND_ROBIN=1, grant the opposite of last_grant; else grant data.
  - On grant, latch address, control, wdata and byteenable into the bus registers. read or write asserts in the next cycle.
- Fetch grant with fetch_addr[1:0]!=0: no bus cycle. Go to RESP with fetch_misaligned=1 and instr unchanged.
- FETCH/DATA: bus outputs stay constant while waitrequest=1.
  - On the first edge with waitrequest=0: capture readdata (loads/fetches only), deassert read/write, go to RESP.
- RESP: pulse instr_valid or data_done for exactly one cycle, update last_grant, go to IDLE. No request is sampled in RESP.
- Minimum latency: request seen in IDLE (cycle 0), strobe in cycle 1, completion pulse in cycle 2. Back-to-back accesses therefore take 3 cycles each.
- Requesters keep req asserted until they see their completion pulse. They must update req by the edge ending RESP.
- Request dropped before it is granted: ignored, nothing is latched. A request cannot be withdrawn after grant.
- Watchdog, when WAIT_LIMIT>0:
  - A counter increments each FETCH/DATA cycle with waitrequest=1 and clears on grant.
  - When the counter reaches WAIT_LIMIT with waitrequest still 1: deassert read/write, set bus_error, go to HALT.
  - No completion pulse is issued on abort.
- HALT: ignore all requests, hold strobes low; leave only on reset.
- Reset asserted mid-transaction: at the next edge, force IDLE and drop the strobes. A pending transaction is abandoned with no completion pulse.
- No combinational path from any input to any output.

Decomposition:
- Package mips_bus_pkg:
  - arb_state_t enum {IDLE, FETCH, DATA, RESP, HALT};
  - grant_t enum {GNT_FETCH, GNT_DATA};
  - BYTEEN_WORD=4'b1111.
- Sub-module mips_wait_watchdog: parameter LIMIT; inputs clk, reset, clear, stall; output expired (registered). It is instantiated only when WAIT_LIMIT>0; otherwise expired is tied to 0.

Test Plan:
- Fetch only: fetch_req=1, fetch_addr=0xBFC00000, waitrequest=0, readdata=0x24020005 → read=1 with address=0xBFC00000 in cycle 1; instr_valid pulse with instr=0x24020005 in cycle 2.
- Stalled store: data_req=1, data_write=1, addr=0x1000, wdata=0xDEADBEEF, be=4'b0011, waitrequest high 3 cycles → write/address/writedata/byteenable stable for 4 cycles; single data_done pulse afterwards; no instr_valid.
- Tie, ROUND_ROBIN=1, both req held across three accesses → grant order fetch, data, fetch. With ROUND_ROBIN=0 → data, data, ... until data_req drops.
- Misaligned fetch 0x00000402 → no read strobe ever; instr_valid=1 and fetch_misaligned=1 two cycles after the request; instr unchanged.
- WAIT_LIMIT=4, waitrequest stuck at 1 → read drops after the 4th stall cycle; bus_error=1 persists; later requests get no response until reset; after reset, a normal fetch succeeds.
- Reset during DATA with waitrequest=1 → next cycle read=write=0, state IDLE, no data_done pulse.
